// File: rtl/pivot_scan_pkg.sv
// rtl/pivot_scan_pkg.sv - shared types and helpers for the pivot search unit
package pivot_pkg;

    // Internal magnitude/index widths; DATWIDTH must not exceed ABS_W.
    localparam int ABS_W = 64;
    localparam int IDX_W = 16;

    typedef enum logic [1:0] {
        IDLE,
        SCAN,
        DONE
    } scan_state_t;

    typedef struct packed {
        logic [ABS_W-1:0] abs;
        logic [IDX_W-1:0] idx;
    } cand_t;

    function automatic int idx_width(input int n);
        return $clog2(n) + 1;
    endfunction

    // Two's-complement magnitude; the most negative value maps to 2^(ABS_W-1) exactly.
    function automatic logic [ABS_W-1:0] abs_u(input logic [ABS_W-1:0] x);
        return x[ABS_W-1] ? (~x + ABS_W'(1)) : x;
    endfunction

endpackage

// File: rtl/pivot_scan_if.sv
// rtl/pivot_scan_if.sv - start/done handshake and result bus of the pivot search unit
interface pivot_scan_if
    import pivot_pkg::*;
#(
    parameter int MAT_SIZE = 8,
    parameter int DATWIDTH = 64,
    parameter int IDXW     = idx_width(MAT_SIZE)
);
    logic                         start;
    logic [IDXW-1:0]              opCnt;
    logic [MAT_SIZE*DATWIDTH-1:0] columnData;
    logic [DATWIDTH-1:0]          tolerance;
    logic                         busy;
    logic                         done;
    logic [IDXW-1:0]              winnerIndex;
    logic [DATWIDTH-1:0]          winnerAbs;
    logic                         winnerNeg;
    logic                         error;
    logic                         rangeErr;

    modport master (
        output start, opCnt, columnData, tolerance,
        input  busy, done, winnerIndex, winnerAbs, winnerNeg, error, rangeErr
    );

    modport slave (
        input  start, opCnt, columnData, tolerance,
        output busy, done, winnerIndex, winnerAbs, winnerNeg, error, rangeErr
    );
endinterface

// File: rtl/pivot_scan_lane_tree.sv
// rtl/pivot_scan_lane_tree.sv - combinational max over one window of LANES rows
module pivot_lane_tree
    import pivot_pkg::*;
#(
    parameter int MAT_SIZE = 8,
    parameter int LANES    = 4
) (
    input  logic [ABS_W-1:0] abs_vals [MAT_SIZE],
    input  logic [IDX_W-1:0] base,
    output cand_t            max_out
);

    cand_t lane_c [LANES];

    // Rows past the end match no entry and read as zero, so they can never win.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            lane_c[l].abs = '0;
            lane_c[l].idx = base + IDX_W'(l);
            for (int i = 0; i < MAT_SIZE; i++) begin
                if (lane_c[l].idx == IDX_W'(i)) begin
                    lane_c[l].abs = abs_vals[i];
                end
            end
        end
    end

    // Strict compare in ascending lane order keeps the lower index on ties.
    always_comb begin
        max_out = lane_c[0];
        for (int l = 1; l < LANES; l++) begin
            if (lane_c[l].abs > max_out.abs) begin
                max_out = lane_c[l];
            end
        end
    end

endmodule

// File: rtl/pivot_scan.sv
// rtl/pivot_scan.sv - pivot search: capture a column, scan LANES rows per cycle, report max
module pivot_scan
    import pivot_pkg::*;
#(
    parameter int MAT_SIZE = 8,
    parameter int DATWIDTH = 64,
    parameter int LANES    = 4,
    parameter int IDXW     = idx_width(MAT_SIZE)
) (
    input  logic       clk,
    input  logic       reset_n,
    pivot_scan_if.slave bus
);

    scan_state_t         state_q, state_d;
    logic [ABS_W-1:0]    abs_q [MAT_SIZE];
    logic [MAT_SIZE-1:0] sign_q;
    logic [DATWIDTH-1:0] tol_q;
    logic [IDX_W-1:0]    p_q;
    cand_t               best_q;
    cand_t               lane_max;
    cand_t               merged;
    logic                merged_neg;

    logic [IDXW-1:0]     res_idx_q;
    logic [DATWIDTH-1:0] res_abs_q;
    logic                res_neg_q;
    logic                err_q;
    logic                range_q;

    logic [IDX_W-1:0]    op_ext;
    logic                op_range;
    logic                last_scan;

    assign op_ext    = IDX_W'(bus.opCnt);
    assign op_range  = (op_ext >= IDX_W'(MAT_SIZE));
    assign last_scan = ((p_q + IDX_W'(LANES)) >= IDX_W'(MAT_SIZE));

    pivot_lane_tree #(
        .MAT_SIZE (MAT_SIZE),
        .LANES    (LANES)
    ) u_lane_tree (
        .abs_vals (abs_q),
        .base     (p_q),
        .max_out  (lane_max)
    );

    // Running best only yields to a strictly larger magnitude.
    assign merged = (lane_max.abs > best_q.abs) ? lane_max : best_q;

    always_comb begin
        merged_neg = 1'b0;
        for (int i = 0; i < MAT_SIZE; i++) begin
            if (merged.idx == IDX_W'(i)) begin
                merged_neg = sign_q[i];
            end
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (bus.start) state_d = op_range ? DONE : SCAN;
            SCAN:    if (last_scan) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            sign_q    <= '0;
            tol_q     <= '0;
            p_q       <= '0;
            best_q    <= '0;
            res_idx_q <= '0;
            res_abs_q <= '0;
            res_neg_q <= 1'b0;
            err_q     <= 1'b0;
            range_q   <= 1'b0;
            for (int i = 0; i < MAT_SIZE; i++) begin
                abs_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (bus.start) begin
                        for (int i = 0; i < MAT_SIZE; i++) begin
                            abs_q[i]  <= abs_u(ABS_W'($signed(bus.columnData[i*DATWIDTH +: DATWIDTH])));
                            sign_q[i] <= bus.columnData[i*DATWIDTH + DATWIDTH - 1];
                        end
                        tol_q       <= bus.tolerance;
                        p_q         <= op_ext;
                        best_q.abs  <= '0;
                        best_q.idx  <= op_ext;
                        if (op_range) begin
                            res_idx_q <= bus.opCnt;
                            res_abs_q <= '0;
                            res_neg_q <= 1'b0;
                            err_q     <= 1'b1;
                            range_q   <= 1'b1;
                        end
                    end
                end
                SCAN: begin
                    p_q    <= p_q + IDX_W'(LANES);
                    best_q <= merged;
                    if (last_scan) begin
                        res_idx_q <= IDXW'(merged.idx);
                        res_abs_q <= DATWIDTH'(merged.abs);
                        res_neg_q <= merged_neg;
                        err_q     <= (merged.abs <= ABS_W'(tol_q));
                        range_q   <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy        = (state_q != IDLE);
    assign bus.done        = (state_q == DONE);
    assign bus.winnerIndex = res_idx_q;
    assign bus.winnerAbs   = res_abs_q;
    assign bus.winnerNeg   = res_neg_q;
    assign bus.error       = err_q;
    assign bus.rangeErr    = range_q;

endmodule
